// File: rtl/uart_rx_frame_check.sv
// UART receive frame checker.
// Takes one mid-bit sample per bit period. It deserializes the data LSB-first
// and accumulates parity serially. It then checks the parity and stop bits and
// publishes good bytes on P_DATA.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | line idle, waiting for a strobe that samples a 0 (start)
//   S_DATA   | shifting in WIDTH data bits, LSB first
//   S_PARITY | next strobe carries the received parity bit
//   S_STOP   | next strobe carries the stop bit; frame verdict is issued
module uart_rx_frame_check #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sampled_bit,
  input  logic             bit_strobe,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic [WIDTH-1:0] P_DATA,
  output logic             data_valid,
  output logic             par_err,
  output logic             stp_err,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             accum_q, accum_d;
  logic             cfg_par_en_q, cfg_par_en_d;
  logic             cfg_par_typ_q, cfg_par_typ_d;
  logic             perr_pend_q, perr_pend_d;
  logic [WIDTH-1:0] p_data_q, p_data_d;
  logic             data_valid_q, data_valid_d;
  logic             par_err_q, par_err_d;
  logic             stp_err_q, stp_err_d;
  logic             busy_q, busy_d;

  // Parity bit the transmitter would have sent for the data accumulated so far.
  logic exp_par;
  assign exp_par = accum_q ^ cfg_par_typ_q;

  // State and datapath registers; reset returns every output to its idle value.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      accum_q       <= 1'b0;
      cfg_par_en_q  <= 1'b0;
      cfg_par_typ_q <= 1'b0;
      perr_pend_q   <= 1'b0;
      p_data_q      <= '0;
      data_valid_q  <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      accum_q       <= accum_d;
      cfg_par_en_q  <= cfg_par_en_d;
      cfg_par_typ_q <= cfg_par_typ_d;
      perr_pend_q   <= perr_pend_d;
      p_data_q      <= p_data_d;
      data_valid_q  <= data_valid_d;
      par_err_q     <= par_err_d;
      stp_err_q     <= stp_err_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state logic: acts only on strobe cycles; the result pulses default low every cycle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    accum_d       = accum_q;
    cfg_par_en_d  = cfg_par_en_q;
    cfg_par_typ_d = cfg_par_typ_q;
    perr_pend_d   = perr_pend_q;
    p_data_d      = p_data_q;
    data_valid_d  = 1'b0;
    par_err_d     = 1'b0;
    stp_err_d     = 1'b0;
    busy_d        = busy_q;

    case (state_q)
      S_IDLE: begin
        if (bit_strobe && !sampled_bit) begin
          // Frame config is frozen here so mid-frame changes cannot corrupt the check.
          state_d       = S_DATA;
          cfg_par_en_d  = PAR_EN;
          cfg_par_typ_d = PAR_TYP;
          cnt_d         = CNT_LOAD;
          shift_d       = '0;
          accum_d       = 1'b0;
          perr_pend_d   = 1'b0;
          busy_d        = 1'b1;
        end
      end

      S_DATA: begin
        if (bit_strobe) begin
          // Shift right so the first data bit ends up in bit 0.
          shift_d = {sampled_bit, shift_q} >> 1;
          accum_d = accum_q ^ sampled_bit;
          if (cnt_q == '0) begin
            state_d = cfg_par_en_q ? S_PARITY : S_STOP;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (bit_strobe) begin
          perr_pend_d = (sampled_bit != exp_par);
          state_d     = S_STOP;
        end
      end

      S_STOP: begin
        if (bit_strobe) begin
          par_err_d    = perr_pend_q;
          stp_err_d    = !sampled_bit;
          data_valid_d = !perr_pend_q && sampled_bit;
          if (!perr_pend_q && sampled_bit) begin
            p_data_d = shift_q;
          end
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;
  assign busy       = busy_q;

endmodule
